reorder_buffer: RTL



---
 rtl/reorder_buffer_if.sv | 47 ++++
 rtl/reorder_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatcher, CDB and commit/rollback signal bundle for the reorder buffer.
// The slave modport is the ROB itself; the master modport is its environment.
interface reorder_buffer_if;
  logic        en_signal_from_dispatcher;
  logic [4:0]  rd_from_dispatcher;
  logic        is_branch_from_dispatcher;
  logic        pred_taken_from_dispatcher;
  logic [4:0]  Q_to_dispatcher;
  logic        full_to_dispatcher;
  logic [4:0]  Q1_from_dispatcher;
  logic [4:0]  Q2_from_dispatcher;
  logic        ready1_to_dispatcher;
  logic        ready2_to_dispatcher;
  logic [31:0] V1_to_dispatcher;
  logic [31:0] V2_to_dispatcher;
  logic        cdb_valid;
  logic [4:0]  cdb_Q;
  logic [31:0] cdb_V;
  logic        cdb_taken;
  logic [31:0] cdb_target_pc;
  logic        commit_flag_to_reg;
  logic [4:0]  rd_to_reg;
  logic [4:0]  Q_to_reg;
  logic [31:0] V_to_reg;
  logic        rollback_flag_to_reg;
  logic [31:0] target_pc_to_fetcher;

  modport slave (
    input  en_signal_from_dispatcher, rd_from_dispatcher, is_branch_from_dispatcher,
    input  pred_taken_from_dispatcher, Q1_from_dispatcher, Q2_from_dispatcher,
    input  cdb_valid, cdb_Q, cdb_V, cdb_taken, cdb_target_pc,
    output Q_to_dispatcher, full_to_dispatcher,
    output ready1_to_dispatcher, ready2_to_dispatcher, V1_to_dispatcher, V2_to_dispatcher,
    output commit_flag_to_reg, rd_to_reg, Q_to_reg, V_to_reg,
    output rollback_flag_to_reg, target_pc_to_fetcher
  );

  modport master (
    output en_signal_from_dispatcher, rd_from_dispatcher, is_branch_from_dispatcher,
    output pred_taken_from_dispatcher, Q1_from_dispatcher, Q2_from_dispatcher,
    output cdb_valid, cdb_Q, cdb_V, cdb_taken, cdb_target_pc,
    input  Q_to_dispatcher, full_to_dispatcher,
    input  ready1_to_dispatcher, ready2_to_dispatcher, V1_to_dispatcher, V2_to_dispatcher,
    input  commit_flag_to_reg, rd_to_reg, Q_to_reg, V_to_reg,
    input  rollback_flag_to_reg, target_pc_to_fetcher
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB writeback, in-order single retire,
// and flush with redirect when a mispredicted branch reaches the head.
module reorder_buffer #(
  parameter int ROB_SIZE = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  bus
);

  localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
  localparam logic [4:0]       SIZE_TAG = 5'(ROB_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROB_SIZE - 1);

  // Entry storage; index i holds tag i+1 so tag 0 can mean "no producer".
  logic              busy_r       [ROB_SIZE];
  logic              ready_r      [ROB_SIZE];
  logic [4:0]        rd_r         [ROB_SIZE];
  logic [31:0]       value_r      [ROB_SIZE];
  logic              is_branch_r  [ROB_SIZE];
  logic              pred_taken_r [ROB_SIZE];
  logic              taken_r      [ROB_SIZE];
  logic [31:0]       entry_pc_r   [ROB_SIZE];

  logic [IDX_W-1:0]  head_r;
  logic [IDX_W-1:0]  tail_r;
  logic [4:0]        count_r;

  logic              commit_flag_r;
  logic [4:0]        commit_rd_r;
  logic [4:0]        commit_q_r;
  logic [31:0]       commit_v_r;
  logic              rollback_flag_r;
  logic [31:0]       redirect_pc_r;

  logic              full_s;
  logic              alloc_s;
  logic              head_commit_s;
  logic              mispredict_s;
  logic              wb_hit_s;
  logic [IDX_W-1:0]  wb_idx_s;
  logic [IDX_W-1:0]  head_next_s;
  logic [IDX_W-1:0]  tail_next_s;
  logic [32:0]       query1_s;
  logic [32:0]       query2_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] res;
    if (idx == LAST_IDX) begin
      res = '0;
    end else begin
      res = idx + IDX_W'(1);
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] tag_to_idx(input logic [4:0] tag);
    return IDX_W'(tag - 5'd1);
  endfunction

  function automatic logic [4:0] idx_to_tag(input logic [IDX_W-1:0] idx);
    return 5'(idx) + 5'd1;
  endfunction

  function automatic logic tag_valid(input logic [4:0] tag);
    return (tag != 5'd0) && (tag <= SIZE_TAG);
  endfunction

  // Stored result wins; otherwise forward a same-cycle CDB broadcast.
  function automatic logic [32:0] query(input logic [4:0] tag, input logic cdb_v,
                                        input logic [4:0] cdb_tag, input logic [31:0] cdb_val);
    logic [32:0]      res;
    logic [IDX_W-1:0] idx;
    idx = tag_to_idx(tag);
    if (tag_valid(tag) && busy_r[idx] && ready_r[idx]) begin
      res = {1'b1, value_r[idx]};
    end else if (tag != 5'd0 && cdb_v && cdb_tag == tag) begin
      res = {1'b1, cdb_val};
    end else begin
      res = 33'd0;
    end
    return res;
  endfunction

  // Control decisions for the coming edge.
  always_comb begin
    full_s        = (count_r == SIZE_TAG);
    alloc_s       = bus.en_signal_from_dispatcher && !full_s;
    head_commit_s = busy_r[head_r] && ready_r[head_r];
    mispredict_s  = head_commit_s && is_branch_r[head_r] &&
                    (taken_r[head_r] != pred_taken_r[head_r]);
    wb_idx_s      = tag_to_idx(bus.cdb_Q);
    if (bus.cdb_valid && tag_valid(bus.cdb_Q)) begin
      wb_hit_s = busy_r[wb_idx_s];
    end else begin
      wb_hit_s = 1'b0;
    end
    head_next_s   = next_idx(head_r);
    tail_next_s   = next_idx(tail_r);
  end

  // Operand lookups for the dispatcher.
  always_comb begin
    query1_s = query(bus.Q1_from_dispatcher, bus.cdb_valid, bus.cdb_Q, bus.cdb_V);
    query2_s = query(bus.Q2_from_dispatcher, bus.cdb_valid, bus.cdb_Q, bus.cdb_V);
  end

  assign bus.Q_to_dispatcher      = idx_to_tag(tail_r);
  assign bus.full_to_dispatcher   = full_s;
  assign bus.ready1_to_dispatcher = query1_s[32];
  assign bus.V1_to_dispatcher     = query1_s[31:0];
  assign bus.ready2_to_dispatcher = query2_s[32];
  assign bus.V2_to_dispatcher     = query2_s[31:0];
  assign bus.commit_flag_to_reg   = commit_flag_r;
  assign bus.rd_to_reg            = commit_rd_r;
  assign bus.Q_to_reg             = commit_q_r;
  assign bus.V_to_reg             = commit_v_r;
  assign bus.rollback_flag_to_reg = rollback_flag_r;
  assign bus.target_pc_to_fetcher = redirect_pc_r;

  // Entry, pointer and retire-port state; everything holds while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_r[i]       <= 1'b0;
        ready_r[i]      <= 1'b0;
        rd_r[i]         <= 5'd0;
        value_r[i]      <= 32'd0;
        is_branch_r[i]  <= 1'b0;
        pred_taken_r[i] <= 1'b0;
        taken_r[i]      <= 1'b0;
        entry_pc_r[i]   <= 32'd0;
      end
      head_r          <= '0;
      tail_r          <= '0;
      count_r         <= 5'd0;
      commit_flag_r   <= 1'b0;
      commit_rd_r     <= 5'd0;
      commit_q_r      <= 5'd0;
      commit_v_r      <= 32'd0;
      rollback_flag_r <= 1'b0;
      redirect_pc_r   <= 32'd0;
    end else if (rdy_in) begin
      commit_flag_r   <= head_commit_s;
      rollback_flag_r <= mispredict_s;
      if (head_commit_s) begin
        commit_rd_r <= rd_r[head_r];
        commit_q_r  <= idx_to_tag(head_r);
        commit_v_r  <= value_r[head_r];
      end
      if (mispredict_s) begin
        redirect_pc_r <= entry_pc_r[head_r];
      end
      if (wb_hit_s) begin
        ready_r[wb_idx_s]    <= 1'b1;
        value_r[wb_idx_s]    <= bus.cdb_V;
        taken_r[wb_idx_s]    <= bus.cdb_taken;
        entry_pc_r[wb_idx_s] <= bus.cdb_target_pc;
      end
      // A flush overrides the head retire bookkeeping and drops any same-edge allocation.
      if (mispredict_s) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          busy_r[i]  <= 1'b0;
          ready_r[i] <= 1'b0;
        end
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= 5'd0;
      end else begin
        if (head_commit_s) begin
          busy_r[head_r]  <= 1'b0;
          ready_r[head_r] <= 1'b0;
          head_r          <= head_next_s;
        end
        if (alloc_s) begin
          busy_r[tail_r]       <= 1'b1;
          ready_r[tail_r]      <= 1'b0;
          rd_r[tail_r]         <= bus.rd_from_dispatcher;
          is_branch_r[tail_r]  <= bus.is_branch_from_dispatcher;
          pred_taken_r[tail_r] <= bus.pred_taken_from_dispatcher;
          taken_r[tail_r]      <= 1'b0;
          tail_r               <= tail_next_s;
        end
        case ({alloc_s, head_commit_s})
          2'b10:   count_r <= count_r + 5'd1;
          2'b01:   count_r <= count_r - 5'd1;
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule
